// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmit serializer states, bit-period helper.
// The uart_rx receiver is expected to move onto these same definitions.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic int clk_per_bit(input int clock, input int baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy flags and first-word-fall-through read data.
// A push while full and a pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   push,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_d;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count_d = count + CW'(do_push) - CW'(do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serializer with optional parity and 1 or 2 stop bits.
//   state     | meaning
//   ST_IDLE   | line high, waiting for a FIFO entry
//   ST_START  | start bit (low) for one bit period
//   ST_DATA   | data bits, LSB first
//   ST_PARITY | parity bit (only when parity is enabled)
//   ST_STOP   | stop bit(s) high; pops the next byte at the end when one is queued
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_SPEED = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        wr_data,
  input  logic                        wr_en,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        tx_serial,
  output logic                        tx_active,
  output logic                        tx_cplt
);

  localparam int   CPB     = clk_per_bit(CLOCK_SPEED, BAUD_RATE);
  localparam int   BAUD_W  = $clog2(CPB);
  localparam int   IDX_W   = $clog2(DATA_BITS);
  localparam logic ODD_PAR = (PARITY == PARITY_ODD);
  localparam logic HAS_PAR = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);

  tx_state_t             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  line_d;
  logic                  active_d;
  logic                  cplt_d;
  logic                  bit_end;
  logic                  pop;
  logic                  empty;
  logic [DATA_BITS-1:0]  rd_data;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .push    (wr_en),
    .pop     (pop),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return ODD_PAR ? ~^d : ^d;
  endfunction

  assign bit_end = (baud_q == BAUD_W'(CPB - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = rd_data;
          par_d   = calc_parity(rd_data);
          state_d = ST_START;
          baud_d  = '0;
          idx_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d = '0;
            // Chain straight into the next start bit to keep the line busy.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = rd_data;
              par_d   = calc_parity(rd_data);
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so the pin matches the state it belongs to.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_d[idx_d];
      ST_PARITY: line_d = par_d;
      default:   line_d = 1'b1;
    endcase
    active_d = (state_d != ST_IDLE);
    cplt_d   = (state_d == ST_STOP) && (baud_d == BAUD_W'(CPB - 1)) &&
               (idx_d == IDX_W'(STOP_BITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_cplt   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_serial <= line_d;
      tx_active <= active_d;
      tx_cplt   <= cplt_d;
      overflow  <= wr_en && full;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameterisations driven by directed and random writes,
// compared every cycle against a frame-schedule model of the line.
module tb_uart_tx_fifo;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  localparam int MAXC  = 8192;
  localparam int PAR[4] = '{0, 2, 1, 0};
  localparam int STB[4] = '{1, 1, 1, 2};

  logic       clk;
  logic       rst_n;
  logic [7:0] wdat [4];
  logic       wen  [4];
  logic       full [4];
  logic [2:0] cnt  [4];
  logic       ovf  [4];
  logic       line [4];
  logic       act  [4];
  logic       cplt [4];

  int n_tests;
  int n_fail;
  int cyc;

  logic [8:0] plan [4][MAXC];
  logic       obs_line [4][MAXC];
  logic       obs_act  [4][MAXC];
  logic       obs_cplt [4][MAXC];
  logic       obs_ovf  [4][MAXC];
  logic       obs_full [4][MAXC];

  int         f_wt  [4][$];
  int         f_st  [4][$];
  logic [7:0] f_dat [4][$];
  bit         rej_now  [4];
  bit         rej_prev [4];

  uart_tx_fifo #(.CLOCK_SPEED(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_data(wdat[0]), .wr_en(wen[0]), .full(full[0]),
    .count(cnt[0]), .overflow(ovf[0]), .tx_serial(line[0]), .tx_active(act[0]), .tx_cplt(cplt[0]));
  uart_tx_fifo #(.CLOCK_SPEED(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_data(wdat[1]), .wr_en(wen[1]), .full(full[1]),
    .count(cnt[1]), .overflow(ovf[1]), .tx_serial(line[1]), .tx_active(act[1]), .tx_cplt(cplt[1]));
  uart_tx_fifo #(.CLOCK_SPEED(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_data(wdat[2]), .wr_en(wen[2]), .full(full[2]),
    .count(cnt[2]), .overflow(ovf[2]), .tx_serial(line[2]), .tx_active(act[2]), .tx_cplt(cplt[2]));
  uart_tx_fifo #(.CLOCK_SPEED(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_data(wdat[3]), .wr_en(wen[3]), .full(full[3]),
    .count(cnt[3]), .overflow(ovf[3]), .tx_serial(line[3]), .tx_active(act[3]), .tx_cplt(cplt[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return CPB * (9 + ((PAR[i] != 0) ? 1 : 0) + STB[i]);
  endfunction

  // Line level at offset 'off' cycles into a frame carrying byte d.
  function automatic logic frame_bit(input int i, input logic [7:0] d, input int off);
    int b;
    int ones;
    b = off / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && PAR[i] != 0) begin
      ones = $countones(d);
      return (PAR[i] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    end
    return 1'b1;
  endfunction

  task automatic model_eval(input int i, input int n, output int occ, output logic ln,
                            output logic ac, output logic cp);
    int st;
    occ = 0;
    ln  = 1'b1;
    ac  = 1'b0;
    cp  = 1'b0;
    for (int k = 0; k < f_wt[i].size(); k++) begin
      st = f_st[i][k];
      if (f_wt[i][k] < n) occ++;
      if (st <= n) occ--;
      if (n >= st && n < st + frame_len(i)) begin
        ac = 1'b1;
        ln = frame_bit(i, f_dat[i][k], n - st);
        if (n == st + frame_len(i) - 1) cp = 1'b1;
      end
    end
  endtask

  // A write is kept unless the buffer already holds DEPTH bytes; its frame starts two
  // cycles later or straight after the previous frame, whichever is later.
  task automatic model_write(input int i, input int n, input logic [7:0] d);
    int occ;
    int st;
    logic l, a, c;
    model_eval(i, n, occ, l, a, c);
    if (occ >= DEPTH) begin
      rej_now[i] = 1'b1;
    end else begin
      st = n + 2;
      if (f_st[i].size() > 0) begin
        if (f_st[i][f_st[i].size()-1] + frame_len(i) > st)
          st = f_st[i][f_st[i].size()-1] + frame_len(i);
      end
      f_wt[i].push_back(n);
      f_st[i].push_back(st);
      f_dat[i].push_back(d);
    end
  endtask

  task automatic run_cycles(input int ncyc);
    int occ;
    logic l, a, c;
    for (int r = 0; r < ncyc; r++) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
        rej_now[i] = 1'b0;
        if (cyc < MAXC && plan[i][cyc][8]) begin
          wen[i]  = 1'b1;
          wdat[i] = plan[i][cyc][7:0];
          model_write(i, cyc, plan[i][cyc][7:0]);
        end else begin
          wen[i]  = 1'b0;
          wdat[i] = 8'($urandom);
        end
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        model_eval(i, cyc, occ, l, a, c);
        check($sformatf("line i%0d c%0d", i, cyc), 32'(line[i]), 32'(l));
        check($sformatf("active i%0d c%0d", i, cyc), 32'(act[i]), 32'(a));
        check($sformatf("cplt i%0d c%0d", i, cyc), 32'(cplt[i]), 32'(c));
        check($sformatf("count i%0d c%0d", i, cyc), 32'(cnt[i]), 32'(occ));
        check($sformatf("full i%0d c%0d", i, cyc), 32'(full[i]), 32'(occ == DEPTH));
        check($sformatf("overflow i%0d c%0d", i, cyc), 32'(ovf[i]), 32'(rej_prev[i]));
        if (cyc < MAXC) begin
          obs_line[i][cyc] = line[i];
          obs_act[i][cyc]  = act[i];
          obs_cplt[i][cyc] = cplt[i];
          obs_ovf[i][cyc]  = ovf[i];
          obs_full[i][cyc] = full[i];
        end
        rej_prev[i] = rej_now[i];
      end
    end
  endtask

  function automatic int count_ones_in(input int i, input int kind, input int lo, input int hi);
    int s;
    s = 0;
    for (int n = lo; n <= hi; n++) begin
      case (kind)
        0: s += int'(obs_line[i][n]);
        1: s += int'(obs_act[i][n]);
        2: s += int'(obs_cplt[i][n]);
        default: s += int'(obs_ovf[i][n]);
      endcase
    end
    return s;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wen[i]      = 1'b0;
      wdat[i]     = 8'h00;
      rej_now[i]  = 1'b0;
      rej_prev[i] = 1'b0;
      for (int n = 0; n < MAXC; n++) begin
        plan[i][n]     = 9'h000;
        obs_line[i][n] = 1'b1;
        obs_act[i][n]  = 1'b0;
        obs_cplt[i][n] = 1'b0;
        obs_ovf[i][n]  = 1'b0;
        obs_full[i][n] = 1'b0;
      end
    end

    // Directed traffic.
    plan[0][10]  = {1'b1, 8'hA5};
    plan[0][200] = {1'b1, 8'h01};
    plan[0][201] = {1'b1, 8'h02};
    plan[0][202] = {1'b1, 8'h03};
    for (int k = 0; k < 6; k++) plan[0][600+k] = {1'b1, 8'(8'h10 + k)};
    plan[1][10] = {1'b1, 8'h07};
    plan[2][10] = {1'b1, 8'h07};
    plan[3][10] = {1'b1, 8'hFF};
    plan[3][11] = {1'b1, 8'h3C};

    // Random traffic with occasional bursts that overrun the buffer.
    for (int n = 1300; n < 5300; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 99) < 3) plan[i][n] = {1'b1, 8'($urandom)};
        if (n < 5290 && $urandom_range(0, 399) == 0)
          for (int k = 0; k < 7; k++) plan[i][n+k] = {1'b1, 8'($urandom)};
      end
    end
    plan[0][6010] = {1'b1, 8'hA5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset line i%0d", i), 32'(line[i]), 32'd1);
      check($sformatf("reset count i%0d", i), 32'(cnt[i]), 32'd0);
      check($sformatf("reset full i%0d", i), 32'(full[i]), 32'd0);
      check($sformatf("reset overflow i%0d", i), 32'(ovf[i]), 32'd0);
      check($sformatf("reset active i%0d", i), 32'(act[i]), 32'd0);
      check($sformatf("reset cplt i%0d", i), 32'(cplt[i]), 32'd0);
    end
    rst_n = 1'b1;

    // Frame at 6012 puts data bit 3 of 0xA5 (a zero) on cycles 6052..6061.
    run_cycles(6055);

    check("pre_reset_line", 32'(obs_line[0][6055]), 32'd0);
    check("pre_reset_active", 32'(obs_act[0][6055]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_line", 32'(line[0]), 32'd1);
    check("async_reset_count", 32'(cnt[0]), 32'd0);
    check("async_reset_active", 32'(act[0]), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      f_wt[i].delete();
      f_st[i].delete();
      f_dat[i].delete();
      rej_prev[i] = 1'b0;
    end
    rst_n = 1'b1;
    run_cycles(300);
    check("post_reset_line_high", 32'(count_ones_in(0, 0, 6056, 6355)), 32'd300);
    check("post_reset_no_cplt", 32'(count_ones_in(0, 2, 6056, 6355)), 32'd0);

    // Boundary scenarios, restated from the frame timing rules.
    check("single_low_t2", 32'(obs_line[0][12]), 32'd0);
    check("single_cplt_t101", 32'(obs_cplt[0][111]), 32'd1);
    check("single_active_falls", 32'(obs_act[0][112]), 32'd0);
    check("b2b_active_len", 32'(count_ones_in(0, 1, 190, 520)), 32'd300);
    check("b2b_cplt_count", 32'(count_ones_in(0, 2, 190, 520)), 32'd3);
    check("b2b_cplt_spacing", 32'(obs_cplt[0][401]), 32'd1);
    check("full_rises", 32'(obs_full[0][605]), 32'd1);
    check("overflow_pulse", 32'(obs_ovf[0][606]), 32'd1);
    check("overflow_once", 32'(count_ones_in(0, 3, 590, 1200)), 32'd1);
    check("overflow_frames", 32'(count_ones_in(0, 2, 590, 1200)), 32'd5);
    check("parity_even_bit", 32'(obs_line[1][105]), 32'd1);
    check("parity_odd_bit", 32'(obs_line[2][105]), 32'd0);
    check("parity_frame_len", 32'(obs_cplt[1][121]), 32'd1);
    check("stop2_high_len", 32'(count_ones_in(3, 0, 102, 121)), 32'd20);
    check("stop2_next_start", 32'(obs_line[3][122]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: accepts bytes from on-chip logic through a write-enable port into a synchronous FIFO and serializes them back-to-back onto the line. The 8N1 framing is extended with optional parity and 1 or 2 stop bits. It is the byte source that keeps the line busy without the producer having to wait on per-byte completion. The block sits between application logic and the TX pin, and its line format matches our `uart_rx` receiver.

## Interface
- `CLOCK_SPEED`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate. `CLK_PER_BIT = CLOCK_SPEED / BAUD_RATE`, integer division, must be ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, 5..8.
- `FIFO_DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `wr_data` in, DATA_BITS: byte to enqueue.
- `wr_en` in, 1: enqueue `wr_data` this cycle.
- `full` out, 1: FIFO holds FIFO_DEPTH entries.
- `count` out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out, 1: one-cycle pulse when `wr_en` is asserted while `full` is high.
- `tx_serial` out, 1: UART line, idle high.
- `tx_active` out, 1: high while a frame is on the line.
- `tx_cplt` out, 1: one-cycle pulse at the end of each frame's last stop bit.

## Operation
- Reset (async assert, sync deassert by design):
  - `tx_serial` = 1.
  - `full`, `count`, `overflow`, `tx_active`, `tx_cplt` = 0.
  - FIFO is emptied and the state machine returns to IDLE.
- Reset mid-frame aborts the frame immediately and drives the line high. The partial frame is not resumed.
- Write rules:
  - `wr_en && !full` pushes `wr_data`.
  - `wr_en && full` drops the byte, pulses `overflow` the next cycle, and leaves the FIFO unchanged.
  - `full` and `count` are registered and reflect a push one cycle after it.
- Push and pop in the same cycle leave `count` unchanged. They are legal at any occupancy except push-when-full, which is dropped even if a pop occurs that cycle.
- Serializer states: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE, or STOP → START when the FIFO is non-empty.
- IDLE:
  - `tx_serial` = 1.
  - If the FIFO is not empty, pop the head into the shift register, compute the parity bit, and go to START.
- START: drive 0 for CLK_PER_BIT cycles.
- DATA: drive the data bits LSB first, each for CLK_PER_BIT cycles, using a bit index 0..DATA_BITS-1.
- PARITY: drive the parity bit for CLK_PER_BIT cycles.
  - Odd parity: the data bits plus parity contain an odd number of ones.
  - Even parity: they contain an even number of ones.
- STOP: drive 1 for STOP_BITS × CLK_PER_BIT cycles.
  - On the last cycle, pulse `tx_cplt`.
  - If the FIFO is non-empty, pop and enter START directly, so there is no idle gap between frames.
- Baud counter:
  - Width $clog2(CLK_PER_BIT); counts 0..CLK_PER_BIT-1, then wraps to 0 on every bit boundary.
  - Cleared on entry to START.
- `tx_active` is high from the first START cycle through the last STOP cycle. It stays high across back-to-back frames.
- Unreachable state encodings go to IDLE with the line high.

## Timing
- Latency from a write into an empty, idle block:
  - Write at cycle t: `count` = 1 at t+1.
  - Pop at t+1.
  - `tx_serial` goes low at t+2.
- Frame length is CLK_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles, exactly.
- Back-to-back frames: the next start bit begins on the cycle after the previous frame's last stop cycle.
- `tx_cplt` and `tx_active` are registered outputs. `overflow` is registered.
- `tx_serial` is registered, so there are no glitches on the pin.

## Structure
- Shared package `uart_pkg`:
  - Parity constants `PARITY_NONE` / `PARITY_ODD` / `PARITY_EVEN`.
  - Serializer state encodings.
  - A `clk_per_bit(clock, baud)` function.
  - `uart_rx` is to be migrated to this package.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) provides:
  - Registered `count` / `full` / `empty`.
  - First-word-fall-through read data.
  - Wrap-around read/write pointers of $clog2(DEPTH) bits.
- The serializer FSM, baud counter, and parity logic live in `uart_tx_fifo`.

## Test plan
Bench parameters: CLOCK_SPEED = 1_000_000, BAUD_RATE = 100_000 (CLK_PER_BIT = 10), DATA_BITS = 8, FIFO_DEPTH = 4.

- **Single byte:** write 0xA5, PARITY = 0.
  - Line low at t+2 for 10 cycles.
  - Bits 1,0,1,0,0,1,0,1 follow, each 10 cycles.
  - Stop bit high for 10 cycles.
  - `tx_cplt` pulses at cycle t+101; `tx_active` falls after it.
- **Parity:** with PARITY = 2, write 0x07 → parity bit 1. With PARITY = 1, write 0x07 → parity bit 0. Frame length is 110 cycles.
- **Back-to-back:** write 0x01, 0x02, 0x03 on consecutive cycles.
  - Three frames with zero idle cycles between them.
  - `tx_active` stays high for 300 cycles.
  - Three `tx_cplt` pulses, 100 cycles apart.
- **Full/overflow:** write 6 bytes in 6 consecutive cycles while the first is being serialized.
  - `full` rises.
  - The 6th write pulses `overflow`.
  - Exactly 5 frames are sent: 1 in flight + 4 buffered.
- **Reset mid-frame:** assert `rst_n` low during the data bit at index 3.
  - `tx_serial` goes to 1 in the same cycle (async).
  - `count` = 0 and `tx_active` = 0.
  - After release, no residual frame is sent.
- **STOP_BITS = 2:** write 0xFF → stop level held for 20 cycles. A queued second byte's start bit follows on the very next cycle.
